decode_stage: RTL and testbench
===============================

# decode_stage

RV32I instruction decode stage: accepts one fetched instruction per cycle, reads `rs1` and `rs2` combinationally from the register file, and registers a fully resolved execute bundle for EX. The bundle contains the ALU op, both ALU operands, destination, branch/jump target, memory controls and an illegal flag. It sits between fetch and the single-cycle ALU/EX stage and is the sole producer of `ALU_*` op codes.

## Interface
Parameters:
- `RISCV_WORD_WIDTH`, 32, datapath width (package constant, not overridden)

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `instr_valid_i`  in  1  fetch offers `instr_i`/`pc_i`
- `instr_ready_o`  out  1  decode accepts this cycle
- `instr_i`  in  32  instruction word
- `pc_i`  in  32  address of `instr_i`
- `rs1_addr_o`, `rs2_addr_o`  out  5  `instr_i[19:15]`, `instr_i[24:20]`, combinational
- `rs1_data_i`, `rs2_data_i`  in  32  register file read data, same cycle
- `flush_i`  in  1  discard registered and incoming instruction
- `ex_valid_o`  out  1  bundle valid
- `ex_ready_i`  in  1  EX consumes bundle
- `ex_alu_op_o`  out  `ALU_OP_WIDTH`  ALU operation
- `ex_operand_a_o`, `ex_operand_b_o`  out  32  ALU operands
- `ex_rd_addr_o`  out  5  destination register; `ex_rd_we_o`  out  1  writeback enable
- `ex_branch_o`  out  1  conditional branch (ALU result bit 0 = taken)
- `ex_jump_o`  out  1  unconditional jump
- `ex_target_o`  out  32  branch/jump target
- `ex_mem_re_o`, `ex_mem_we_o`  out  1  load / store
- `ex_funct3_o`  out  3  access size/sign
- `ex_store_data_o`  out  32  rs2 data
- `ex_pc_o`  out  32  instruction PC
- `ex_illegal_o`  out  1  illegal instruction

## Operation
- Accept = `instr_valid_i && instr_ready_o`. `instr_ready_o = !flush_i && (!ex_valid_o || ex_ready_i)`.
- Decode is combinational from `instr_i`, `pc_i` and rs data. On accept, all `ex_*` outputs are loaded.
- Operand mapping (a, b, op):
  - LUI: imm_u, 0, ALU_PASS.
  - AUIPC: pc, imm_u, ALU_ADD.
  - OP-IMM: rs1, imm_i, funct3 → ADD/LTS/LTU/XOR/OR/AND/SLL/SRL/SRA. Shift b = zero-extended `imm[4:0]`. SRAI requires funct7=0x20.
  - OP: rs1, rs2. funct7=0x20 legal only for ADD→SUB and SRL→SRA; every other funct7 ≠ 0 is illegal.
  - BRANCH: rs1, rs2, funct3 → EQ/NE/LTS/GES/LTU/GEU. Target = pc+imm_b, rd_we=0.
  - JAL: pc, 4, ADD, jump. Target = pc+imm_j.
  - JALR: pc, 4, ADD, jump. Target = (rs1+imm_i) & ~1.
  - LOAD: rs1, imm_i, ADD, mem_re.
  - STORE: rs1, imm_s, ADD, mem_we, rd_we=0.
  - MISC-MEM (FENCE): ALU_PASS NOP with all enables 0.
- Illegal cases: unknown opcode, `instr_i[1:0] != 2'b11`, undefined funct3/funct7, and SYSTEM. These set `ex_illegal_o=1` and force rd_we, mem_re, mem_we, branch and jump to 0.
- `ex_rd_we_o` is forced to 0 when rd = x0.
- Immediates are sign-extended to 32 bits; all additions wrap modulo 2^32.

## Timing
- Latency 1 cycle, from accept to `ex_valid_o`. Throughput 1 instruction/cycle.
- While `ex_valid_o && !ex_ready_i`, every `ex_*` output holds stable and `instr_ready_o`=0.
- `ex_valid_o` next-state, in priority order:
  1. `flush_i` → 0
  2. accept → 1
  3. `ex_ready_i` → 0
  4. otherwise hold
- Flush has priority over a simultaneous accept. The incoming instruction is not consumed because `instr_ready_o`=0.
- Reset: takes effect immediately, including mid-stall. `ex_valid_o`=0, all `ex_*` data=0, `ex_alu_op_o`=ALU_PASS. `instr_ready_o` is 1 once `rst_i` deasserts.

## Structure
- `riscv_defines` package: `RISCV_WORD_WIDTH`, opcode/funct3/funct7 constants, `decode_bundle_t` struct for the registered bundle.
- `alu_defines` package: `ALU_OP_WIDTH` and all `ALU_*` codes, shared unchanged with the ALU.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction, selected by opcode.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), rs1_data=10 → next cycle: ex_valid_o=1, ALU_ADD, a=10, b=0xFFFFFFFD, rd=5, we=1.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=9 → ALU_SUB, a=7, b=9. The same encoding with funct7=0x01 → ex_illegal_o=1, we=0.
- BNE x1,x2,-8 (0xFE209CE3) at pc=0x100 → ALU_NE, branch=1, target=0x000000F8, we=0.
- Backpressure: ex_ready_i low for 3 cycles with the next instruction valid → instr_ready_o=0 and outputs frozen; the next instruction is accepted on the cycle ex_ready_i rises.
- flush_i together with valid input and a pending bundle → ex_valid_o=0 next cycle, input not accepted. 0x00000000 → ex_illegal_o=1 with all enables 0.
- rst_i pulsed mid-stall → ex_valid_o=0 without a clock edge. ADDI x0 → ex_rd_we_o=0.

Source files
------------

// File: rtl/alu_defines.sv
// alu_defines: ALU operation codes shared between decode and the ALU.
package alu_defines;
  localparam int ALU_OP_WIDTH = 4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS = 4'd14;
endpackage

// File: rtl/riscv_defines.sv
// riscv_defines: RV32I encodings, the registered execute bundle and funct3-to-op helpers.
package riscv_defines;
  import alu_defines::*;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]     alu_op;
    logic [RISCV_WORD_WIDTH-1:0] operand_a;
    logic [RISCV_WORD_WIDTH-1:0] operand_b;
    logic [4:0]                  rd_addr;
    logic                        rd_we;
    logic                        branch;
    logic                        jump;
    logic [RISCV_WORD_WIDTH-1:0] target;
    logic                        mem_re;
    logic                        mem_we;
    logic [2:0]                  funct3;
    logic [RISCV_WORD_WIDTH-1:0] store_data;
    logic [RISCV_WORD_WIDTH-1:0] pc;
    logic                        illegal;
  } decode_bundle_t;
  function automatic logic [ALU_OP_WIDTH-1:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_LTS;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [ALU_OP_WIDTH-1:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_EQ;
      3'b001:  return ALU_NE;
      3'b100:  return ALU_LTS;
      3'b101:  return ALU_GES;
      3'b110:  return ALU_LTU;
      3'b111:  return ALU_GEU;
      default: return ALU_PASS;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate of the format implied by the opcode.
module imm_gen
  import riscv_defines::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);
  logic [6:0] opc;
  assign opc = instr_i[6:0];
  always_comb begin
    imm_o = (opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR) ? {{20{instr_i[31]}}, instr_i[31:20]} :
            (opc == OPC_STORE)  ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            (opc == OPC_BRANCH) ? {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            (opc == OPC_LUI || opc == OPC_AUIPC) ? {instr_i[31:12], 12'b0} :
            (opc == OPC_JAL)    ? {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            32'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, turning a fetched instruction into a registered execute bundle.
module decode_stage
  import alu_defines::*;
  import riscv_defines::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_valid_i,
  output logic                        instr_ready_o,
  input  logic [31:0]                 instr_i,
  input  logic [31:0]                 pc_i,
  output logic [4:0]                  rs1_addr_o,
  output logic [4:0]                  rs2_addr_o,
  input  logic [31:0]                 rs1_data_i,
  input  logic [31:0]                 rs2_data_i,
  input  logic                        flush_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [ALU_OP_WIDTH-1:0]     ex_alu_op_o,
  output logic [31:0]                 ex_operand_a_o,
  output logic [31:0]                 ex_operand_b_o,
  output logic [4:0]                  ex_rd_addr_o,
  output logic                        ex_rd_we_o,
  output logic                        ex_branch_o,
  output logic                        ex_jump_o,
  output logic [31:0]                 ex_target_o,
  output logic                        ex_mem_re_o,
  output logic                        ex_mem_we_o,
  output logic [2:0]                  ex_funct3_o,
  output logic [31:0]                 ex_store_data_o,
  output logic [31:0]                 ex_pc_o,
  output logic                        ex_illegal_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm;
  logic accept, ill, we, valid_q, valid_d;
  decode_bundle_t bundle_d, bundle_q;
  assign opc = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign instr_ready_o = !flush_i && (!valid_q || ex_ready_i);
  assign accept = instr_valid_i && instr_ready_o;
  imm_gen u_imm_gen (.instr_i(instr_i), .imm_o(imm));
  always_comb begin
    bundle_d = '0;
    bundle_d.alu_op = ALU_PASS;
    bundle_d.rd_addr = instr_i[11:7];
    bundle_d.funct3 = f3;
    bundle_d.store_data = rs2_data_i;
    bundle_d.pc = pc_i;
    ill = 1'b0;
    we = 1'b0;
    case (opc)
      OPC_LUI: begin
        bundle_d.operand_a = imm;
        we = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_d.operand_a = pc_i;
        bundle_d.operand_b = imm;
        bundle_d.alu_op = ALU_ADD;
        we = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle_d.operand_a = rs1_data_i;
        bundle_d.operand_b = (f3 == F3_SLL || f3 == F3_SR) ? {27'b0, imm[4:0]} : imm;
        bundle_d.alu_op = arith_op(f3, f3 == F3_SR && f7 == F7_ALT);
        we = 1'b1;
        ill = (f3 == F3_SLL && f7 != F7_ZERO) || (f3 == F3_SR && f7 != F7_ZERO && f7 != F7_ALT);
      end
      OPC_OP: begin
        bundle_d.operand_a = rs1_data_i;
        bundle_d.operand_b = rs2_data_i;
        bundle_d.alu_op = arith_op(f3, f7 == F7_ALT);
        we = 1'b1;
        ill = !(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OPC_BRANCH: begin
        bundle_d.operand_a = rs1_data_i;
        bundle_d.operand_b = rs2_data_i;
        bundle_d.alu_op = branch_op(f3);
        bundle_d.branch = 1'b1;
        bundle_d.target = pc_i + imm;
        ill = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JAL, OPC_JALR: begin
        bundle_d.operand_a = pc_i;
        bundle_d.operand_b = 32'd4;
        bundle_d.alu_op = ALU_ADD;
        bundle_d.jump = 1'b1;
        bundle_d.target = (opc == OPC_JAL) ? pc_i + imm : (rs1_data_i + imm) & ~32'd1;
        we = 1'b1;
        ill = (opc == OPC_JALR && f3 != 3'b000);
      end
      OPC_LOAD, OPC_STORE: begin
        bundle_d.operand_a = rs1_data_i;
        bundle_d.operand_b = imm;
        bundle_d.alu_op = ALU_ADD;
        bundle_d.mem_re = (opc == OPC_LOAD);
        bundle_d.mem_we = (opc == OPC_STORE);
        we = (opc == OPC_LOAD);
        ill = (opc == OPC_LOAD) ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) : (f3 > 3'b010);
      end
      OPC_MISC_MEM: ill = (f3 != 3'b000);
      default: ill = 1'b1;
    endcase
    ill = ill || (instr_i[1:0] != 2'b11);
    bundle_d.illegal = ill;
    bundle_d.rd_we = we && !ill && (instr_i[11:7] != 5'd0);
    bundle_d.branch = bundle_d.branch && !ill;
    bundle_d.jump = bundle_d.jump && !ill;
    bundle_d.mem_re = bundle_d.mem_re && !ill;
    bundle_d.mem_we = bundle_d.mem_we && !ill;
  end
  assign valid_d = flush_i ? 1'b0 : accept ? 1'b1 : ex_ready_i ? 1'b0 : valid_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      bundle_q <= '0;
      bundle_q.alu_op <= ALU_PASS;
    end else begin
      valid_q <= valid_d;
      if (accept) bundle_q <= bundle_d;
    end
  end
  assign ex_valid_o = valid_q;
  assign ex_alu_op_o = bundle_q.alu_op;
  assign ex_operand_a_o = bundle_q.operand_a;
  assign ex_operand_b_o = bundle_q.operand_b;
  assign ex_rd_addr_o = bundle_q.rd_addr;
  assign ex_rd_we_o = bundle_q.rd_we;
  assign ex_branch_o = bundle_q.branch;
  assign ex_jump_o = bundle_q.jump;
  assign ex_target_o = bundle_q.target;
  assign ex_mem_re_o = bundle_q.mem_re;
  assign ex_mem_we_o = bundle_q.mem_we;
  assign ex_funct3_o = bundle_q.funct3;
  assign ex_store_data_o = bundle_q.store_data;
  assign ex_pc_o = bundle_q.pc;
  assign ex_illegal_o = bundle_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors checked against a table-driven decode model every cycle.
module tb_decode_stage;
  import alu_defines::*;
  import riscv_defines::*;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic instr_valid_i = 1'b0, flush_i = 1'b0, ex_ready_i = 1'b1;
  logic [31:0] instr_i = '0, pc_i = '0, rs1_data_i = '0, rs2_data_i = '0;
  logic instr_ready_o, ex_valid_o, ex_rd_we_o, ex_branch_o, ex_jump_o;
  logic ex_mem_re_o, ex_mem_we_o, ex_illegal_o;
  logic [4:0] rs1_addr_o, rs2_addr_o, ex_rd_addr_o;
  logic [ALU_OP_WIDTH-1:0] ex_alu_op_o;
  logic [31:0] ex_operand_a_o, ex_operand_b_o, ex_target_o, ex_store_data_o, ex_pc_o;
  logic [2:0] ex_funct3_o;
  int total = 0, bad = 0;
  logic m_valid;
  decode_bundle_t m_b, got, rst_b;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .ex_alu_op_o(ex_alu_op_o), .ex_operand_a_o(ex_operand_a_o),
    .ex_operand_b_o(ex_operand_b_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .ex_target_o(ex_target_o),
    .ex_mem_re_o(ex_mem_re_o), .ex_mem_we_o(ex_mem_we_o), .ex_funct3_o(ex_funct3_o),
    .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_illegal_o(ex_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Reference decode written as lookup tables plus per-opcode rules.
  function automatic decode_bundle_t model(input logic [31:0] ins, pc, r1, r2);
    decode_bundle_t e;
    logic [ALU_OP_WIDTH-1:0] ar [8] = '{ALU_ADD, ALU_SLL, ALU_LTS, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [ALU_OP_WIDTH-1:0] br [8] = '{ALU_EQ, ALU_NE, ALU_PASS, ALU_PASS, ALU_LTS, ALU_GES, ALU_LTU, ALU_GEU};
    logic [31:0] ii, is, ib, iu, ij;
    logic [2:0] f;
    logic [6:0] f7;
    logic ill, wr;
    f = ins[14:12];
    f7 = ins[31:25];
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu = {ins[31:12], 12'h000};
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e = '0;
    e.alu_op = ALU_PASS;
    e.rd_addr = ins[11:7];
    e.funct3 = f;
    e.store_data = r2;
    e.pc = pc;
    ill = 1'b0;
    wr = 1'b0;
    case (ins[6:0])
      7'h37: begin e.operand_a = iu; wr = 1; end
      7'h17: begin e.operand_a = pc; e.operand_b = iu; e.alu_op = ALU_ADD; wr = 1; end
      7'h13: begin
        e.operand_a = r1;
        e.operand_b = (f == 1 || f == 5) ? 32'(ins[24:20]) : ii;
        e.alu_op = (f == 5 && f7 == 7'h20) ? ALU_SRA : ar[f];
        ill = (f == 1 && f7 != 0) || (f == 5 && !(f7 == 0 || f7 == 7'h20));
        wr = 1;
      end
      7'h33: begin
        e.operand_a = r1;
        e.operand_b = r2;
        e.alu_op = (f7 == 7'h20 && f == 0) ? ALU_SUB : (f7 == 7'h20 && f == 5) ? ALU_SRA : ar[f];
        ill = !(f7 == 0 || (f7 == 7'h20 && (f == 0 || f == 5)));
        wr = 1;
      end
      7'h63: begin
        e.operand_a = r1; e.operand_b = r2; e.alu_op = br[f];
        e.branch = 1; e.target = pc + ib; ill = (br[f] == ALU_PASS);
      end
      7'h6F: begin e.operand_a = pc; e.operand_b = 4; e.alu_op = ALU_ADD; e.jump = 1; e.target = pc + ij; wr = 1; end
      7'h67: begin
        e.operand_a = pc; e.operand_b = 4; e.alu_op = ALU_ADD; e.jump = 1;
        e.target = {r1[31:1] + ii[31:1] + 31'(r1[0] & ii[0]), 1'b0}; ill = (f != 0); wr = 1;
      end
      7'h03: begin e.operand_a = r1; e.operand_b = ii; e.alu_op = ALU_ADD; e.mem_re = 1; ill = !(f inside {0, 1, 2, 4, 5}); wr = 1; end
      7'h23: begin e.operand_a = r1; e.operand_b = is; e.alu_op = ALU_ADD; e.mem_we = 1; ill = !(f inside {0, 1, 2}); end
      7'h0F: ill = (f != 0);
      default: ill = 1;
    endcase
    if (ill) begin
      e.branch = 0; e.jump = 0; e.mem_re = 0; e.mem_we = 0; wr = 0;
    end
    e.illegal = ill;
    e.rd_we = wr && (ins[11:7] != 0);
    return e;
  endfunction

  // Check the combinational outputs, step the model and the DUT one edge, then compare state.
  task automatic cycle();
    logic rdy;
    #1;
    rdy = !flush_i && (!m_valid || ex_ready_i);
    chk("instr_ready", 192'(instr_ready_o), 192'(rdy));
    chk("rs_addr", 192'({rs1_addr_o, rs2_addr_o}), 192'({instr_i[19:15], instr_i[24:20]}));
    if (flush_i) m_valid = 0;
    else if (instr_valid_i && rdy) begin m_valid = 1; m_b = model(instr_i, pc_i, rs1_data_i, rs2_data_i); end
    else if (ex_ready_i) m_valid = 0;
    @(posedge clk_i);
    #1;
    got = '{alu_op: ex_alu_op_o, operand_a: ex_operand_a_o, operand_b: ex_operand_b_o,
            rd_addr: ex_rd_addr_o, rd_we: ex_rd_we_o, branch: ex_branch_o, jump: ex_jump_o,
            target: ex_target_o, mem_re: ex_mem_re_o, mem_we: ex_mem_we_o, funct3: ex_funct3_o,
            store_data: ex_store_data_o, pc: ex_pc_o, illegal: ex_illegal_o};
    chk("ex_valid", 192'(ex_valid_o), 192'(m_valid));
    chk("bundle", 192'(got), 192'(m_b));
  endtask

  task automatic issue(input logic [31:0] ins, pc, r1, r2);
    instr_valid_i = 1; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    cycle();
  endtask

  logic [31:0] vec [14] = '{32'h123453B7, 32'h00001417, 32'h010000EF, 32'h005100E7, 32'h0081A203,
                            32'h00532623, 32'h40315093, 32'h40311093, 32'h0FF0000F, 32'h00000073,
                            32'h0020B4B3, 32'h0020A063, 32'h00208290, 32'h40008093};

  initial begin
    rst_b = '0;
    rst_b.alu_op = ALU_PASS;
    m_b = rst_b;
    m_valid = 0;
    #2 rst_i = 1;
    #1;
    chk("reset_valid_async", 192'(ex_valid_o), 192'(0));
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("reset_alu_op", 192'(ex_alu_op_o), 192'(ALU_PASS));
    chk("reset_data", 192'({ex_operand_a_o, ex_target_o, ex_pc_o, ex_illegal_o}), 192'(0));
    rst_i = 0;
    #1;
    chk("ready_after_reset", 192'(instr_ready_o), 192'(1));
    issue(32'hFFD08293, 32'h0, 32'd10, 32'd0);
    chk("addi_lit", 192'({ex_valid_o, ex_alu_op_o, ex_operand_a_o, ex_operand_b_o, ex_rd_addr_o, ex_rd_we_o}),
        192'({1'b1, ALU_ADD, 32'd10, 32'hFFFFFFFD, 5'd5, 1'b1}));
    issue(32'h402081B3, 32'h4, 32'd7, 32'd9);
    chk("sub_lit", 192'({ex_alu_op_o, ex_operand_a_o, ex_operand_b_o, ex_illegal_o}), 192'({ALU_SUB, 32'd7, 32'd9, 1'b0}));
    issue(32'h022081B3, 32'h8, 32'd7, 32'd9);
    chk("bad_f7_lit", 192'({ex_illegal_o, ex_rd_we_o}), 192'({1'b1, 1'b0}));
    issue(32'hFE209CE3, 32'h100, 32'd1, 32'd2);
    chk("bne_lit", 192'({ex_alu_op_o, ex_branch_o, ex_target_o, ex_rd_we_o}), 192'({ALU_NE, 1'b1, 32'h000000F8, 1'b0}));
    issue(32'h00000000, 32'h104, 32'd1, 32'd2);
    chk("zero_lit", 192'({ex_illegal_o, ex_rd_we_o, ex_mem_re_o, ex_mem_we_o, ex_branch_o, ex_jump_o}), 192'(6'b100000));
    issue(32'h00100013, 32'h108, 32'd3, 32'd0);
    chk("addi_x0_lit", 192'({ex_rd_we_o, ex_illegal_o, ex_operand_b_o}), 192'({1'b0, 1'b0, 32'd1}));
    issue(32'h005100E7, 32'h10C, 32'h1000, 32'd0);
    chk("jalr_lit", 192'({ex_jump_o, ex_target_o, ex_operand_b_o}), 192'({1'b1, 32'h00001004, 32'd4}));
    foreach (vec[i]) issue(vec[i], 32'h200 + 32'(i) * 4, 32'h8000_0000 + 32'(i), 32'h1234_0000 + 32'(i));
    issue(32'hFFD08293, 32'h300, 32'd20, 32'd0);
    ex_ready_i = 0;
    instr_i = 32'h0020B4B3; pc_i = 32'h304; rs1_data_i = 1; rs2_data_i = 2;
    for (int k = 0; k < 3; k++) cycle();
    chk("stall_frozen", 192'({ex_valid_o, ex_pc_o, ex_operand_a_o}), 192'({1'b1, 32'h300, 32'd20}));
    ex_ready_i = 1;
    cycle();
    chk("after_stall_lit", 192'({ex_pc_o, ex_alu_op_o}), 192'({32'h304, ALU_LTU}));
    ex_ready_i = 0;
    flush_i = 1;
    instr_i = 32'h00100093; pc_i = 32'h308;
    cycle();
    chk("flush_lit", 192'(ex_valid_o), 192'(0));
    flush_i = 0;
    ex_ready_i = 1;
    cycle();
    chk("after_flush_lit", 192'({ex_valid_o, ex_pc_o}), 192'({1'b1, 32'h308}));
    ex_ready_i = 0;
    instr_i = 32'h00200113; pc_i = 32'h30C;
    cycle();
    rst_i = 1;
    #1;
    chk("reset_mid_stall", 192'({ex_valid_o, ex_alu_op_o, ex_pc_o}), 192'({1'b0, ALU_PASS, 32'd0}));
    m_valid = 0;
    m_b = rst_b;
    @(posedge clk_i);
    #1;
    rst_i = 0;
    instr_valid_i = 0;
    ex_ready_i = 1;
    cycle();
    issue(32'h00100013, 32'h400, 32'd5, 32'd0);
    instr_valid_i = 0;
    cycle();
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
